pingpong_number_repeater: RTL

- Successor to the single-bank number repeater. Buffers complete multi-word numbers (BITS_IN_NUM bits, REGISTER_SIZE-bit words) in two BRAM banks.
- Replays each stored number REPLAY_COUNT times to a downstream consumer, paced by the consumer's handshake.
- Ping-pong banking lets the producer write the next number while the previous one drains.
- Sits between encryptor/multiplier stages that emit and consume numbers word-serially, LSW first.

---
 rtl/pingpong_number_repeater.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pingpong_number_repeater.sv
// Ping-pong number repeater: buffers whole multi-word numbers in two BRAM
// banks. Each stored number is replayed REPLAY_COUNT times to a
// handshake-paced consumer while the producer fills the other bank.
// Optional build macro REPEATER_REVERSE_EN adds reverse_in, which selects
// descending word order for a whole bank drain.
module pingpong_number_repeater #(
    parameter int BITS_IN_NUM   = 4096,
    parameter int REGISTER_SIZE = 32,
    parameter int REPLAY_COUNT  = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [REGISTER_SIZE-1:0] data_in,
    input  logic                     data_valid_in,
`ifdef REPEATER_REVERSE_EN
    input  logic                     reverse_in,
`endif
    output logic                     in_ready_out,
    input  logic                     prev_data_consumed_in,
    output logic [REGISTER_SIZE-1:0] data_out,
    output logic                     data_valid_out,
    output logic                     last_out,
    output logic                     overflow_out
);
    localparam int WORDS = BITS_IN_NUM / REGISTER_SIZE;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW    = (REPLAY_COUNT > 1) ? $clog2(REPLAY_COUNT) : 1;
    localparam logic [AW-1:0] ADDR_LAST = AW'(WORDS - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(REPLAY_COUNT - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                   state, state_nxt;
    logic [1:0]               full;
    logic                     wr_bank, rd_bank;
    logic [AW-1:0]            wr_addr, rd_addr;
    logic [PW-1:0]            pass;
    logic                     wr_en, wr_done;
    logic                     issue, issue_last, free_bank, start;
    logic [AW-1:0]            addr_first, addr_end, addr_next, start_addr;
    logic [REGISTER_SIZE-1:0] mem0 [WORDS];
    logic [REGISTER_SIZE-1:0] mem1 [WORDS];
    logic [REGISTER_SIZE-1:0] rdq0_p1, rdq1_p1, rdata_p2;
    logic                     sel_p1;
    logic                     vld_p1, vld_p2, last_p1, last_p2;

    assign in_ready_out = !full[wr_bank];
    assign wr_en        = data_valid_in && in_ready_out;
    assign wr_done      = wr_en && (wr_addr == ADDR_LAST);

`ifdef REPEATER_REVERSE_EN
    logic rev;

    // Direction latched when a bank drain starts, held until the bank is freed
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)  rev <= 1'b0;
        else if (start) rev <= reverse_in;
    end

    assign start_addr = reverse_in ? ADDR_LAST : '0;
    assign addr_first = rev ? ADDR_LAST : '0;
    assign addr_end   = rev ? '0 : ADDR_LAST;
    assign addr_next  = rev ? (rd_addr - AW'(1)) : (rd_addr + AW'(1));
`else
    assign start_addr = '0;
    assign addr_first = '0;
    assign addr_end   = ADDR_LAST;
    assign addr_next  = rd_addr + AW'(1);
`endif

    // Write address/bank sequencing and sticky overflow on dropped words
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_addr      <= '0;
            wr_bank      <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_done) begin
                    wr_addr <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_addr <= wr_addr + AW'(1);
                end
            end
            if (data_valid_in && !in_ready_out) overflow_out <= 1'b1;
        end
    end

    // Bank occupancy: filling and freeing always hit different banks
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            full <= 2'b00;
        end else begin
            if (wr_done)   full[wr_bank] <= 1'b1;
            if (free_bank) full[rd_bank] <= 1'b0;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    // Read FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = DRAIN;
            DRAIN:   if (free_bank) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read FSM outputs: start of drain, read issue, end of pass, bank release
    always_comb begin
        start      = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        free_bank  = 1'b0;
        case (state)
            IDLE:  start = full[rd_bank];
            DRAIN: begin
                issue      = prev_data_consumed_in;
                issue_last = issue && (rd_addr == addr_end);
                free_bank  = issue_last && (pass == PASS_LAST);
            end
            default: ;
        endcase
    end

    // Read address, pass counter and read bank; wraps immediately for gapless replays
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_addr <= '0;
            pass    <= '0;
            rd_bank <= 1'b0;
        end else if (start) begin
            rd_addr <= start_addr;
            pass    <= '0;
        end else if (issue) begin
            if (issue_last) begin
                rd_addr <= addr_first;
                if (free_bank) begin
                    pass    <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    pass <= pass + PW'(1);
                end
            end else begin
                rd_addr <= addr_next;
            end
        end
    end

    // Bank 0 BRAM: write port and read-first registered read port
    always_ff @(posedge clk_in) begin
        if (wr_en && (wr_bank == 1'b0)) mem0[wr_addr] <= data_in;
        if (issue && (rd_bank == 1'b0)) rdq0_p1 <= mem0[rd_addr];
    end

    // Bank 1 BRAM: write port and read-first registered read port
    always_ff @(posedge clk_in) begin
        if (wr_en && (wr_bank == 1'b1)) mem1[wr_addr] <= data_in;
        if (issue && (rd_bank == 1'b1)) rdq1_p1 <= mem1[rd_addr];
    end

    // ---- stage p1 -> p2: BRAM output register and bank select ----
    always_ff @(posedge clk_in) begin
        if (issue) sel_p1 <= rd_bank;
        rdata_p2 <= sel_p1 ? rdq1_p1 : rdq0_p1;
    end

    // Valid/last pipeline tracking the two-cycle BRAM read latency
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
        end else begin
            vld_p1  <= issue;
            last_p1 <= issue_last;
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
        end
    end

    assign data_out       = rdata_p2;
    assign data_valid_out = vld_p2;
    assign last_out       = last_p2;
endmodule
